shift_seq: RTL
==============

# shift_seq

Parametrised sequential universal shift register, the WIDTH-generic successor of the cascaded 4-bit universal shift register datapath. It executes one command per start pulse: parallel load, clear, hold, or a multi-bit logical/arithmetic/rotate shift of `amt` positions performed one bit per clock. A busy/done handshake controls sequencing. It sits in the calculation datapath beside the ALU and serves shift instructions and serial-in data capture.

## Interface
- `WIDTH`, default 32: register width; must be ≥ 2.
- `AW`, default `$clog2(WIDTH)+1`: shift-amount width (derived; do not override).
- `clk` in 1: clock; all state changes on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `start` in 1: command strobe; accepted only when `busy`=0.
- `op` in 3: command; sampled at the accepting edge.
- `amt` in AW: shift count; sampled at the accepting edge.
- `sl` in 1: serial fill into bit 0 for SLL; sampled at every shift edge.
- `sr` in 1: serial fill into bit WIDTH-1 for SRL; sampled at every shift edge.
- `pdata` in WIDTH: parallel load data; sampled at the accepting edge.
- `q` out WIDTH: register contents.
- `co` out 1: last bit shifted out.
- `busy` out 1: high while a command is in progress.
- `done` out 1: high for exactly one cycle when a command completes.

## Operation
- `op` encoding:
  - 000 HOLD, 001 LOAD, 010 SLL, 011 SRL, 100 SRA (fill = current q[WIDTH-1]), 101 ROL, 110 ROR, 111 CLR.
- FSM states: IDLE, RUN, DONE. `busy` = (state≠IDLE). `done` = (state==DONE).
- IDLE with `start`=1 at the accepting edge E0:
  - LOAD: `q`←`pdata`, `co`←0, go DONE.
  - CLR: `q`←0, `co`←0, go DONE.
  - HOLD: no change, go DONE.
  - Shift op with `amt`=0: `q` and `co` unchanged, go DONE.
  - Shift op with `amt`=N>0: latch op, count←N, go RUN.
- RUN, each edge: shift `q` by one bit per the latched op, `co`←the bit leaving the register, count←count-1. When count reaches 1 at that edge, go DONE.
- DONE: the next edge returns to IDLE unconditionally.
- `start` while `busy`=1 (RUN or DONE) is ignored. No queuing.
- `amt` ≥ WIDTH is executed literally, with no clamping:
  - Logical shifts then hold only fill bits.
  - Rotates wrap; e.g. `amt`=WIDTH+1 gives the same `q` as `amt`=1.
- `op`, `amt` and `pdata` changing during RUN have no effect. `sl` and `sr` stay live, so a serial stream can be clocked in.

## Timing
- Reset values: `q`=0, `co`=0, `busy`=0, `done`=0, state IDLE.
- `clear` acts immediately, without waiting for a clock edge, from any state, including mid-RUN. The partial shift is discarded.
- After `clear` deasserts, the first edge can accept `start`.
- Single-cycle commands (LOAD, CLR, HOLD, shift with `amt`=0):
  - `q` updates at E0.
  - `busy`=`done`=1 for the one cycle after E0.
  - The next accept is possible at E0+2.
- Shift of N>0:
  - Shifts occur at E1..EN.
  - `busy` is high for N+1 cycles; `done` is high in the last of them, with the final `q` and `co` valid.
  - The next accept is possible at E0+N+2.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `shift_seq_pkg`: op encoding localparams (OP_HOLD…OP_CLR) and the state enum (IDLE/RUN/DONE).
- Sub-module `shift_step`: purely combinational one-bit step.
  - Inputs: `q`, op, `sl`, `sr`.
  - Outputs: next `q` and the out-bit.
- The top level contains the FSM, the down-counter, and the `q`/`co` registers.

## Test plan
All scenarios use WIDTH=8.
- **Reset mid-shift:** LOAD 8'hFF, start SLL `amt`=6, assert `clear` after 2 shifts → `q`=0, `co`=0, `busy`=0, `done`=0 immediately, before the next edge.
- **SLL with fill:** LOAD 8'hA5; SLL `amt`=3, `sl`=1 → `q`=8'h2F, `co`=1; `busy` high 4 cycles, `done` in the 4th.
- **SRA:** LOAD 8'h90; SRA `amt`=2 → `q`=8'hE4, `co`=0.
- **Rotate beyond width:** LOAD 8'h81; ROR `amt`=9 → `q`=8'hC0, `co`=1; `busy` high 10 cycles.
- **Ignored start and zero amount:**
  - LOAD 8'h3C; start SRL `amt`=4; pulse start with LOAD 8'h00 during RUN → ignored, final `q`=8'h03 (`sr`=0).
  - Then SRL `amt`=0 → `q`=8'h03, `co` unchanged, `done` one cycle after start.
- **Serial capture:** CLR; SRL `amt`=8 with `sr` = 1,0,1,1,0,0,1,0 on successive shift edges → `q`=8'h4D.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequential universal shift register:
// command encodings, controller states and a command classifier.
package shift_seq_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the five commands that move bits one position per clock.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// One-bit shift step: combinational next value of the register and the
// bit that falls off the end for a single shift/rotate position.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sl,
    input  logic             sr,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // Select the shifted value and exiting bit for the requested op.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (op)
            OP_SLL: begin
                q_next  = {q[WIDTH-2:0], sl};
                out_bit = q[WIDTH-1];
            end
            OP_SRL: begin
                q_next  = {sr, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_SRA: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential universal shift register. One command per start pulse;
// multi-bit shifts advance one position per clock under a down-counter,
// with busy/done handshaking for the surrounding datapath.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_co;

    state_t           w_state_nxt;
    logic [2:0]       w_op_nxt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_co_nxt;

    logic [WIDTH-1:0] w_step_q;
    logic             w_step_co;

    // The step always works from the latched op so op changes during RUN are inert.
    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (r_q),
        .op     (r_op),
        .sl     (sl),
        .sr     (sr),
        .q_next (w_step_q),
        .out_bit(w_step_co)
    );

    // Next-state, counter and datapath selection for the command controller.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_co_nxt    = r_co;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        w_q_nxt     = pdata;
                        w_co_nxt    = 1'b0;
                        w_state_nxt = DONE;
                    end else if (op == OP_CLR) begin
                        w_q_nxt     = '0;
                        w_co_nxt    = 1'b0;
                        w_state_nxt = DONE;
                    end else if (is_shift_op(op) && (amt != '0)) begin
                        w_op_nxt    = op;
                        w_cnt_nxt   = amt;
                        w_state_nxt = RUN;
                    end else begin
                        // HOLD and zero-length shifts complete without touching q/co.
                        w_state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                w_q_nxt   = w_step_q;
                w_co_nxt  = w_step_co;
                w_cnt_nxt = r_cnt - AW'(1);
                if (r_cnt == AW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers; clear wipes everything at once.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_co    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_co    <= w_co_nxt;
        end
    end

    assign q    = r_q;
    assign co   = r_co;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
